// File: rtl/ysyx_22040088_ifu.sv
// ysyx_22040088_ifu -- instruction fetch unit for the ysyx_22040088 multi-cycle core.
//
// Owns the architectural PC. It fetches one instruction at a time, holds it for
// decode, then commits the next PC chosen by execute. A misaligned target makes
// the unit stop in a terminal FAULT state until reset.
//
// Ports
//   clk_i, rst_i          clock, synchronous active-high reset
//   pc_o                  current PC (feeds pcbranch)
//   pcadd_i .. beqpc_i    next-PC candidates from pcbranch
//   next_valid_i          execute is done; commit next PC (EXEC only)
//   next_sel_i            00 pcadd, 01 jalpc, 10 jalrpc, 11 beqpc
//   imem_req_valid_o/_ready_i, imem_addr_o   fetch request channel
//   imem_rsp_valid_i, imem_rdata_i           fetch response (one-cycle pulse)
//   inst_valid_o/inst_ready_i, inst_o, inst_pc_o   instruction to decode
//   fetch_fault_o, fault_pc_o   sticky misaligned-target flag and address
//   retire_cnt_o          committed-instruction count
//   state_o               current FSM state (debug visibility)
//
// Handshakes: a transfer happens on a rising edge where valid and ready are both
// high. valid is a function of the FSM state only, never of the matching ready,
// and once raised it stays high with stable payload until the transfer.

module ysyx_22040088_ifu #(
  parameter logic [63:0] RESET_PC = 64'h8000_0000
) (
  input  logic        clk_i,
  input  logic        rst_i,
  output logic [63:0] pc_o,
  input  logic [63:0] pcadd_i,
  input  logic [63:0] jalpc_i,
  input  logic [63:0] jalrpc_i,
  input  logic [63:0] beqpc_i,
  input  logic        next_valid_i,
  input  logic [1:0]  next_sel_i,
  output logic        imem_req_valid_o,
  input  logic        imem_req_ready_i,
  output logic [63:0] imem_addr_o,
  input  logic        imem_rsp_valid_i,
  input  logic [31:0] imem_rdata_i,
  output logic        inst_valid_o,
  input  logic        inst_ready_i,
  output logic [31:0] inst_o,
  output logic [63:0] inst_pc_o,
  output logic        fetch_fault_o,
  output logic [63:0] fault_pc_o,
  output logic [63:0] retire_cnt_o,
  output logic [2:0]  state_o
);

  typedef enum logic [2:0] {
    S_REQ   = 3'd0,
    S_WAIT  = 3'd1,
    S_HOLD  = 3'd2,
    S_EXEC  = 3'd3,
    S_FAULT = 3'd4
  } state_e;

  state_e      state_q, state_d;
  logic [63:0] pc_q, pc_d;
  logic [31:0] inst_q, inst_d;
  logic [63:0] inst_pc_q, inst_pc_d;
  logic        fault_q, fault_d;
  logic [63:0] fault_pc_q, fault_pc_d;
  logic [63:0] retire_q, retire_d;
  logic [63:0] target;

  // Candidate mux; only consumed in EXEC when next_valid_i is high.
  always_comb begin
    target = pcadd_i;
    case (next_sel_i)
      2'b00: target = pcadd_i;
      2'b01: target = jalpc_i;
      2'b10: target = jalrpc_i;
      2'b11: target = beqpc_i;
      default: target = pcadd_i;
    endcase
  end

  always_comb begin
    state_d    = state_q;
    pc_d       = pc_q;
    inst_d     = inst_q;
    inst_pc_d  = inst_pc_q;
    fault_d    = fault_q;
    fault_pc_d = fault_pc_q;
    retire_d   = retire_q;
    case (state_q)
      S_REQ: begin
        if (imem_req_ready_i) state_d = S_WAIT;
      end
      S_WAIT: begin
        if (imem_rsp_valid_i) begin
          inst_d    = imem_rdata_i;
          inst_pc_d = pc_q;
          state_d   = S_HOLD;
        end
      end
      S_HOLD: begin
        if (inst_ready_i) state_d = S_EXEC;
      end
      S_EXEC: begin
        if (next_valid_i) begin
          retire_d = retire_q + 64'd1;
          if (target[1:0] == 2'b00) begin
            pc_d    = target;
            state_d = S_REQ;
          end else begin
            fault_d    = 1'b1;
            fault_pc_d = target;
            state_d    = S_FAULT;
          end
        end
      end
      S_FAULT: begin
        state_d = S_FAULT;
      end
      default: begin
        state_d = S_REQ;
      end
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q    <= S_REQ;
      pc_q       <= RESET_PC;
      inst_q     <= 32'h0;
      inst_pc_q  <= 64'h0;
      fault_q    <= 1'b0;
      fault_pc_q <= 64'h0;
      retire_q   <= 64'h0;
    end else begin
      state_q    <= state_d;
      pc_q       <= pc_d;
      inst_q     <= inst_d;
      inst_pc_q  <= inst_pc_d;
      fault_q    <= fault_d;
      fault_pc_q <= fault_pc_d;
      retire_q   <= retire_d;
    end
  end

  // Request is suppressed while reset is held so nothing is issued in the
  // reset cycle itself; there is no path from imem_req_ready_i.
  assign imem_req_valid_o = (state_q == S_REQ) && !rst_i;
  assign imem_addr_o      = pc_q;
  assign inst_valid_o     = (state_q == S_HOLD);
  assign pc_o             = pc_q;
  assign inst_o           = inst_q;
  assign inst_pc_o        = inst_pc_q;
  assign fetch_fault_o    = fault_q;
  assign fault_pc_o       = fault_pc_q;
  assign retire_cnt_o     = retire_q;
  assign state_o          = state_q;

endmodule

// File: tb/tb_ysyx_22040088_ifu.sv
module tb_ysyx_22040088_ifu;

  localparam logic [63:0] RST_PC = 64'h8000_0000;

  // clock / reset
  logic clk_i = 1'b0;
  logic rst_i = 1'b1;
  always #5 clk_i = ~clk_i;

  logic [63:0] pc_o, pcadd_i, jalpc_i, jalrpc_i, beqpc_i;
  logic        next_valid_i;
  logic [1:0]  next_sel_i;
  logic        imem_req_valid_o, imem_req_ready_i;
  logic [63:0] imem_addr_o;
  logic        imem_rsp_valid_i;
  logic [31:0] imem_rdata_i;
  logic        inst_valid_o, inst_ready_i;
  logic [31:0] inst_o;
  logic [63:0] inst_pc_o;
  logic        fetch_fault_o;
  logic [63:0] fault_pc_o, retire_cnt_o;
  logic [2:0]  state_o;

  ysyx_22040088_ifu dut (
    .clk_i(clk_i), .rst_i(rst_i), .pc_o(pc_o),
    .pcadd_i(pcadd_i), .jalpc_i(jalpc_i), .jalrpc_i(jalrpc_i), .beqpc_i(beqpc_i),
    .next_valid_i(next_valid_i), .next_sel_i(next_sel_i),
    .imem_req_valid_o(imem_req_valid_o), .imem_req_ready_i(imem_req_ready_i),
    .imem_addr_o(imem_addr_o), .imem_rsp_valid_i(imem_rsp_valid_i),
    .imem_rdata_i(imem_rdata_i), .inst_valid_o(inst_valid_o),
    .inst_ready_i(inst_ready_i), .inst_o(inst_o), .inst_pc_o(inst_pc_o),
    .fetch_fault_o(fetch_fault_o), .fault_pc_o(fault_pc_o),
    .retire_cnt_o(retire_cnt_o), .state_o(state_o)
  );

  // scoreboard
  logic [63:0] exp_q[$];       // expected fetch addresses, in order
  logic [31:0] exp_inst_q[$];  // instruction words handed to the DUT
  logic [63:0] model_pc, model_retire;
  logic [31:0] last_inst;
  int n_checks = 0;
  int n_pass   = 0;
  int n_fail   = 0;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    assert (obs === exp) n_pass++;
    else begin
      n_fail++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // inputs change and outputs are sampled 1 time unit after the rising edge
  task automatic step();
    @(posedge clk_i);
    #1;
  endtask

  task automatic idle_inputs();
    next_valid_i     = 1'b0;
    next_sel_i       = 2'b00;
    imem_req_ready_i = 1'b0;
    imem_rsp_valid_i = 1'b0;
    imem_rdata_i     = 32'h0;
    inst_ready_i     = 1'b0;
  endtask

  task automatic do_reset();
    idle_inputs();
    rst_i = 1'b1;
    step();
    step();
    chk("rst_req_valid", 64'(imem_req_valid_o), 64'd0);
    chk("rst_pc", pc_o, RST_PC);
    chk("rst_inst", 64'(inst_o), 64'h0);
    chk("rst_inst_pc", inst_pc_o, 64'h0);
    chk("rst_inst_valid", 64'(inst_valid_o), 64'd0);
    chk("rst_fault", 64'(fetch_fault_o), 64'd0);
    chk("rst_fault_pc", fault_pc_o, 64'h0);
    chk("rst_retire", retire_cnt_o, 64'h0);
    rst_i = 1'b0;
    #1;
    chk("post_rst_req_valid", 64'(imem_req_valid_o), 64'd1);
    chk("post_rst_addr", imem_addr_o, RST_PC);
    exp_q.delete();
    exp_inst_q.delete();
    exp_q.push_back(RST_PC);
    model_pc     = RST_PC;
    model_retire = 64'h0;
    last_inst    = 32'h0;
  endtask

  // One full REQ -> WAIT -> HOLD -> EXEC transaction with optional stalls.
  // spur pulses next_valid/imem_rsp_valid in states where they must be ignored.
  task automatic fetch_one(input int req_stall, input int rsp_delay, input int hold_stall,
                           input bit spur, input logic [1:0] sel,
                           input logic [63:0] pa, input logic [63:0] ja,
                           input logic [63:0] jra, input logic [63:0] ba);
    logic [63:0] addr, target;
    logic [31:0] word, got;
    int n;
    pcadd_i = pa; jalpc_i = ja; jalrpc_i = jra; beqpc_i = ba;
    n = 0;
    while (imem_req_valid_o !== 1'b1 && n < 10) begin
      step();
      n++;
    end
    chk("req_valid", 64'(imem_req_valid_o), 64'd1);
    addr = (exp_q.size() > 0) ? exp_q.pop_front() : 64'hx;
    chk("fetch_addr", imem_addr_o, addr);
    // request backpressure
    for (int i = 0; i < req_stall; i++) begin
      imem_req_ready_i = 1'b0;
      next_valid_i     = spur && (i == 0);
      imem_rsp_valid_i = spur && (i == 0);
      imem_rdata_i     = 32'hdead_beef;
      step();
      chk("req_stall_valid", 64'(imem_req_valid_o), 64'd1);
      chk("req_stall_addr", imem_addr_o, addr);
      chk("req_stall_inst", 64'(inst_o), 64'(last_inst));
      chk("req_stall_retire", retire_cnt_o, model_retire);
    end
    next_valid_i = 1'b0; imem_rsp_valid_i = 1'b0;
    imem_req_ready_i = 1'b1;
    step();
    imem_req_ready_i = 1'b0;
    chk("wait_req_valid", 64'(imem_req_valid_o), 64'd0);
    // response delay
    for (int i = 0; i < rsp_delay; i++) begin
      next_valid_i = spur && (i == 0);
      step();
      chk("wait_inst_valid", 64'(inst_valid_o), 64'd0);
      chk("wait_pc", pc_o, addr);
      chk("wait_retire", retire_cnt_o, model_retire);
    end
    next_valid_i = 1'b0;
    word = $urandom();
    exp_inst_q.push_back(word);
    imem_rsp_valid_i = 1'b1;
    imem_rdata_i     = word;
    step();
    imem_rsp_valid_i = 1'b0;
    imem_rdata_i     = 32'h0;
    chk("hold_inst_valid", 64'(inst_valid_o), 64'd1);
    got = (exp_inst_q.size() > 0) ? exp_inst_q.pop_front() : 32'hx;
    chk("hold_inst", 64'(inst_o), 64'(got));
    chk("hold_inst_pc", inst_pc_o, addr);
    // decode backpressure
    for (int i = 0; i < hold_stall; i++) begin
      inst_ready_i     = 1'b0;
      next_valid_i     = spur && (i == 0);
      imem_rsp_valid_i = spur && (i == 0);
      imem_rdata_i     = 32'hdead_beef;
      step();
      chk("hold_stall_valid", 64'(inst_valid_o), 64'd1);
      chk("hold_stall_inst", 64'(inst_o), 64'(got));
      chk("hold_stall_inst_pc", inst_pc_o, addr);
      chk("hold_stall_pc", pc_o, addr);
      chk("hold_stall_retire", retire_cnt_o, model_retire);
    end
    next_valid_i = 1'b0; imem_rsp_valid_i = 1'b0;
    inst_ready_i = 1'b1;
    step();
    inst_ready_i = 1'b0;
    chk("exec_inst_valid", 64'(inst_valid_o), 64'd0);
    last_inst = got;
    // commit
    case (sel)
      2'b00: target = pa;
      2'b01: target = ja;
      2'b10: target = jra;
      default: target = ba;
    endcase
    next_sel_i   = sel;
    next_valid_i = 1'b1;
    step();
    next_valid_i = 1'b0;
    next_sel_i   = 2'b00;
    model_retire = model_retire + 64'd1;
    if (target[1:0] == 2'b00) begin
      model_pc = target;
      exp_q.push_back(target);
      chk("commit_fault", 64'(fetch_fault_o), 64'd0);
    end else begin
      chk("fault_flag", 64'(fetch_fault_o), 64'd1);
      chk("fault_pc", fault_pc_o, target);
      chk("fault_state", 64'(state_o), 64'd4);
    end
    chk("commit_pc", pc_o, model_pc);
    chk("commit_retire", retire_cnt_o, model_retire);
  endtask

  initial begin
    idle_inputs();
    pcadd_i = '0; jalpc_i = '0; jalrpc_i = '0; beqpc_i = '0;

    // reset and sequential zero-wait fetch
    do_reset();
    for (int k = 0; k < 3; k++)
      fetch_one(0, 0, 0, 1'b0, 2'b00, model_pc + 64'd4,
                64'h1000, 64'h2000, 64'h3000);
    chk("seq_retire3", retire_cnt_o, 64'd3);

    // backpressure: 3 cycles req stall, 2 cycles response delay, 2 cycles decode stall
    fetch_one(3, 2, 2, 1'b0, 2'b00, model_pc + 64'd4, 64'h1000, 64'h2000, 64'h3000);

    // redirect select 01/10/11/00
    fetch_one(0, 0, 0, 1'b0, 2'b01, 64'h8000_0014, 64'h8000_0100, 64'h8000_0200, 64'h8000_0300);
    fetch_one(0, 0, 0, 1'b0, 2'b10, 64'h8000_0104, 64'h8000_0100, 64'h8000_0200, 64'h8000_0300);
    fetch_one(0, 0, 0, 1'b0, 2'b11, 64'h8000_0204, 64'h8000_0100, 64'h8000_0200, 64'h8000_0300);
    fetch_one(1, 1, 0, 1'b0, 2'b00, 64'h8000_0304, 64'h8000_0100, 64'h8000_0200, 64'h8000_0300);

    // spurious pulses in REQ/WAIT/HOLD; full 64-bit jump target
    fetch_one(1, 1, 1, 1'b1, 2'b01, 64'h8000_0308, 64'h0000_0001_0000_0400,
              64'h8000_0200, 64'h8000_0300);

    // misaligned target enters FAULT
    fetch_one(0, 0, 0, 1'b0, 2'b10, model_pc + 64'd4, 64'h8000_0100,
              64'h8000_0202, 64'h8000_0300);
    for (int i = 0; i < 4; i++) begin
      imem_req_ready_i = 1'b1;
      next_valid_i     = 1'b1;
      imem_rsp_valid_i = 1'b1;
      inst_ready_i     = 1'b1;
      step();
      chk("fault_no_req", 64'(imem_req_valid_o), 64'd0);
      chk("fault_hold_state", 64'(state_o), 64'd4);
      chk("fault_hold_pc", pc_o, 64'h0000_0001_0000_0400);
      chk("fault_hold_retire", retire_cnt_o, model_retire);
      chk("fault_hold_fpc", fault_pc_o, 64'h8000_0202);
    end
    idle_inputs();

    // reset in WAIT, then a stale response right after release
    do_reset();
    imem_req_ready_i = 1'b1;
    step();
    imem_req_ready_i = 1'b0;
    chk("mid_wait_state", 64'(state_o), 64'd1);
    rst_i = 1'b1;
    step();
    chk("mid_rst_req_valid", 64'(imem_req_valid_o), 64'd0);
    rst_i = 1'b0;
    imem_rsp_valid_i = 1'b1;
    imem_rdata_i     = 32'h1234_5678;
    step();
    imem_rsp_valid_i = 1'b0;
    imem_rdata_i     = 32'h0;
    chk("stale_rsp_inst", 64'(inst_o), 64'h0);
    chk("stale_rsp_inst_valid", 64'(inst_valid_o), 64'd0);
    chk("stale_rsp_fault", 64'(fetch_fault_o), 64'd0);
    chk("stale_rsp_retire", retire_cnt_o, 64'd0);
    fetch_one(0, 0, 0, 1'b0, 2'b00, RST_PC + 64'd4, 64'h1000, 64'h2000, 64'h3000);
    chk("after_rst_retire", retire_cnt_o, 64'd1);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

  // global time bound so the run always terminates
  initial begin
    #200000;
    $display("FAIL timeout observed=running expected=finished");
    $fatal(1, "timeout");
  end

endmodule

// File: doc/ysyx_22040088_ifu.md
# ysyx_22040088_ifu

Instruction fetch unit for the ysyx_22040088 multi-cycle core. It owns the architectural PC register and fetches one instruction at a time from instruction memory over a valid/ready request plus response-valid interface. It presents the fetched instruction to decode, then commits the next PC from the pcbranch candidates (pcadd/jalpc/jalrpc/beqpc) selected by execute. It also flags misaligned fetch targets and counts retired instructions.

## Interface
- RESET_PC, 64'h8000_0000, PC loaded on reset; must be 4-byte aligned.
- clk  in  1  core clock; all state updates on rising edge.
- rst  in  1  synchronous, active-high reset.
- pc  out  64  current PC register; drives pcbranch `pc`.
- pcadd, jalpc, jalrpc, beqpc  in  64 each  next-PC candidates from pcbranch.
- next_valid  in  1  execute has finished the current instruction; commit next PC this cycle.
- next_sel  in  2  candidate select: 00 pcadd, 01 jalpc, 10 jalrpc, 11 beqpc.
- imem_req_valid  out  1  fetch request valid.
- imem_req_ready  in  1  memory accepts request.
- imem_addr  out  64  fetch address (= pc).
- imem_rsp_valid  in  1  response data valid (one-cycle pulse).
- imem_rdata  in  32  instruction word.
- inst_valid  out  1  instruction available to decode.
- inst_ready  in  1  decode accepts instruction.
- inst  out  32  registered instruction word.
- inst_pc  out  64  PC of `inst`.
- fetch_fault  out  1  sticky misaligned-target flag.
- fault_pc  out  64  offending target address.
- retire_cnt  out  64  committed-instruction count.

## Operation
- FSM states: REQ, WAIT, HOLD, EXEC, FAULT.
- REQ: imem_req_valid=1, imem_addr=pc. If imem_req_ready=1, go to WAIT.
- WAIT: imem_req_valid=0. On imem_rsp_valid=1, latch imem_rdata into inst and pc into inst_pc, then go to HOLD.
- HOLD: inst_valid=1. inst and inst_pc are stable. If inst_ready=1, go to EXEC.
- EXEC: the selected candidate is target. When next_valid=1:
  - retire_cnt increments by 1 (mod 2^64).
  - If target[1:0]==0: pc<=target, go to REQ.
  - Otherwise: fetch_fault<=1, fault_pc<=target, pc unchanged, go to FAULT.
- FAULT: terminal. All outputs hold and no requests are issued. Only rst exits.
- next_valid outside EXEC is ignored: no PC change, no count.
- imem_rsp_valid outside WAIT is ignored and dropped.
- inst_ready outside HOLD is ignored.
- next_sel is sampled only in the cycle next_valid=1 in EXEC.
- PC arithmetic: none internal. Candidates are used as-is, full 64 bits, with no truncation.
- Reset: state=REQ, pc=RESET_PC, inst=32'h0, inst_pc=0, inst_valid=0, imem_req_valid=0 during the reset cycle, fetch_fault=0, fault_pc=0, retire_cnt=0.
- Reset mid-operation (any state) aborts the transaction. A pending memory response arriving after reset lands in REQ and is dropped. Memory shares rst.

## Timing
- imem_req_valid is driven from state only, with no combinational path from imem_req_ready.
- inst_valid is driven from state only.
- First cycle after rst deasserts: imem_req_valid=1, imem_addr=RESET_PC.
- Request accepted at cycle N: earliest imem_rsp_valid is N+1; inst_valid is high from the cycle after imem_rsp_valid.
- Zero-wait loop: REQ(accept) -> WAIT(rsp) -> HOLD(ready) -> EXEC(next_valid) -> REQ gives minimum 4 cycles per instruction.
- pc changes only on the edge ending an EXEC cycle with next_valid=1, and is visible the next cycle. pcbranch outputs are therefore stable from REQ through EXEC.
- imem_addr is stable while imem_req_valid=1 and imem_req_ready=0.

## Test plan
- Reset/sequential fetch: rst then release; memory zero-wait, next_valid each EXEC, next_sel=00, pcadd=pc+4. Required: imem_addr 8000_0000, 8000_0004, 8000_0008; each inst_pc matches; retire_cnt=3 after three commits.
- Backpressure: imem_req_ready low 3 cycles, response delayed 2 cycles, inst_ready low 2 cycles. Required: imem_addr, inst and inst_pc stay stable throughout; exactly one request is accepted; latency stretches by exactly the stall cycles.
- Redirect select: in four EXECs, apply next_sel=01/10/11/00 with jalpc=8000_0100, jalrpc=8000_0200, beqpc=8000_0300, pcadd=8000_0304. Required: the next four fetch addresses equal those values in order.
- Misaligned target: next_sel=10, jalrpc=8000_0202. Required: fetch_fault=1, fault_pc=8000_0202, FSM enters FAULT, no further imem_req_valid, pc unchanged, retire_cnt incremented once.
- Spurious inputs: next_valid pulsed in REQ/WAIT/HOLD; imem_rsp_valid pulsed in REQ/HOLD. Required: no pc change, no count change, inst unchanged.
- Reset mid-WAIT: assert rst while in WAIT, then deliver imem_rsp_valid the cycle after release. Required: response dropped; imem_addr=8000_0000 is re-requested; retire_cnt=0; fetch_fault cleared.
